vga_fb_scaler: RTL and testbench
================================

# vga_fb_scaler

Read-side address generator and pixel formatter between the dual-port frame buffer and the VGA driver, in the 25 MHz display domain. It maps each VGA position to a frame-buffer address and replaces the fixed 1x, top-left mapping with run-time selectable 1x/2x/4x integer upscaling and optional centring. Address generation uses counters, with no multiplier. Pixel data is realigned for RAM read latency, and a programmable border colour is substituted outside the image window.

## Interface
Parameters:
- CAM_X, 160, frame-buffer width in pixels.
- CAM_Y, 120, frame-buffer height in pixels.
- AW, 15, address width. Must satisfy 2^AW > CAM_X*CAM_Y.
- DW, 12, pixel width (RGB444).
- H_ACTIVE, 640, visible VGA columns.
- V_ACTIVE, 480, visible VGA rows.
- RAM_LAT, 1, synchronous read latency of the frame buffer in cycles (≥1).

Ports:
- clk  in  1  pixel clock (25 MHz). Single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- scale_sel  in  2  0 selects 1x, 1 selects 2x, 2 selects 4x; 3 is reserved and treated as 1x.
- center_en  in  1  1 centres the image; 0 anchors it at the top-left.
- border_color  in  DW  colour shown outside the image window.
- vga_posX  in  10  next-pixel column from the VGA driver.
- vga_posY  in  10  next-pixel row from the VGA driver.
- ram_addr  out  AW  frame-buffer read address.
- ram_data  in  DW  frame-buffer read data.
- pixel_out  out  DW  pixel sent to the VGA driver.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- Scale factor s = 1, 2 or 4, with k = log2 s.
- Frame start is detected when (vga_posX, vga_posY) equals (0,0) and the previous cycle's value was not (0,0).
- On frame start:
  - frame_start pulses.
  - scale_sel and center_en are latched. Changes mid-frame are ignored.
  - Origin is computed: ox = (H_ACTIVE − CAM_X·s)/2 and oy = (V_ACTIVE − CAM_Y·s)/2, floored, when centring; otherwise ox = oy = 0.
  - Row counters clear.
- Image window: ox ≤ posX < ox + CAM_X·s and oy ≤ posY < oy + CAM_Y·s.
- Address inside the window must equal ((posY−oy)>>k)·CAM_X + ((posX−ox)>>k).
- The address is built from counters:
  - row_base advances by CAM_X each time the vertical repeat counter wraps s−1→0.
  - The column counter advances each time the horizontal repeat counter wraps.
  - Column counters resynchronise at posX == ox on every window row.
- Outside the window, ram_addr = CAM_X·CAM_Y (the black slot) and pixel_out = border_color.
- States:
  - WAIT_FRAME (after reset): output is border only; leaves on frame start.
  - ACTIVE: remains until reset.
- Reset values: ram_addr = CAM_X·CAM_Y, pixel_out = 0, frame_start = 0, state WAIT_FRAME, latched mode = 1x with no centring.
- Reset mid-frame takes effect asynchronously. Border colour is output until the next frame start; no partial image is shown.

## Timing
- posX/posY sampled at edge n: ram_addr is valid after edge n, and pixel_out is valid after edge n+1+RAM_LAT. Total latency is 2 cycles at default RAM_LAT. The VGA driver integration compensates for this.
- The in-window flag is delayed RAM_LAT cycles to stay aligned with ram_data.
- frame_start is asserted for exactly the cycle after edge n in which (0,0) was first sampled.
- Boundaries:
  - posX = ox+CAM_X·s−1 is the last in-window column.
  - Address CAM_X·CAM_Y−1 (19199) occurs only at the bottom-right window pixel.
  - Blanking positions (posX ≥ H_ACTIVE or posY ≥ V_ACTIVE) are outside the window.

## Structure
- Shared package `cam_vga_pkg` holds CAM_X, CAM_Y, AW, DW, H_ACTIVE, V_ACTIVE, the scale_sel encoding constants, and the black-slot constant CAM_X·CAM_Y.
- Sub-module `pix_delay_line` (parametrised depth and width) aligns the in-window flag with RAM data.
- Counters, the FSM and origin calculation stay in the top of this block.

## Test plan
- Reset asserted: ram_addr = 19200, pixel_out = 0 and frame_start = 0 immediately. Border colour is output until (0,0) is seen, after which frame_start pulses once.
- 1x, no centring: (5,2) gives ram_addr 325 one cycle later. (160,0) gives 19200, and pixel_out = border two cycles later.
- 2x, no centring: (7,3) gives 163. (319,239) gives 19199. (320,0) gives border.
- 1x, centred: (240,180) gives 0. (239,180) gives border. (399,299) gives 19199.
- scale_sel changed 0→2 mid-frame: 1x addressing persists until the next (0,0). Afterwards, (639,479) gives 19199 and (4,4) gives 161.
- RAM_LAT = 3 build, with a RAM model returning addr as data: pixel_out equals the address presented four cycles earlier, and the border is applied on exactly the matching cycles.

Source files
------------

// File: rtl/cam_vga_pkg.sv
// Shared constants for the camera frame buffer and VGA display path.
// Geometry, pixel format, scale-select encoding and the black-slot address.
package cam_vga_pkg;

    localparam int CAM_X    = 160;
    localparam int CAM_Y    = 120;
    localparam int AW       = 15;
    localparam int DW       = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    // One past the last pixel; the frame buffer keeps a black word here.
    localparam int BLACK_SLOT = CAM_X * CAM_Y;

    typedef enum logic {
        WAIT_FRAME,
        ACTIVE
    } scaler_state_t;

    // Maps scale_sel to log2 of the scale factor; the reserved code behaves as 1x.
    function automatic logic [1:0] scale_shift(input logic [1:0] sel);
        case (sel)
            SCALE_2X: scale_shift = 2'd1;
            SCALE_4X: scale_shift = 2'd2;
            default:  scale_shift = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Fixed-depth shift register used to keep side-band flags aligned with
// frame-buffer read data.
module pix_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: these stages carry control flags, so unlike a data RAM they are
    // reset; a stale flag would let RAM data through as a visible pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_scaler.sv
// Frame-buffer read address generator with 1x/2x/4x integer upscaling,
// optional centring and border substitution outside the image window.
module vga_fb_scaler #(
    parameter int CAM_X    = cam_vga_pkg::CAM_X,
    parameter int CAM_Y    = cam_vga_pkg::CAM_Y,
    parameter int AW       = cam_vga_pkg::AW,
    parameter int DW       = cam_vga_pkg::DW,
    parameter int H_ACTIVE = cam_vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = cam_vga_pkg::V_ACTIVE,
    parameter int RAM_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    scale_sel,
    input  logic          center_en,
    input  logic [DW-1:0] border_color,
    input  logic [9:0]    vga_posX,
    input  logic [9:0]    vga_posY,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_data,
    output logic [DW-1:0] pixel_out,
    output logic          frame_start
);
    import cam_vga_pkg::*;

    localparam int            XW       = 12;
    localparam logic [AW-1:0] BLACK    = AW'(CAM_X * CAM_Y);
    localparam logic [AW-1:0] ROW_STEP = AW'(CAM_X);

    scaler_state_t state, state_next;

    logic [1:0]    k_lat, k_eff, rep_last;
    logic          center_lat, c_eff;
    logic [9:0]    prev_x, prev_y;
    logic          fs_det, new_line, active, in_win;
    logic [XW-1:0] px, py, win_w, win_h, ox, oy;
    logic [1:0]    hrep, hrep_n, vrep, vrep_n;
    logic [AW-1:0] col, col_n, row_base, row_n;
    logic          win_q, win_d;

    assign fs_det   = (vga_posX == '0) && (vga_posY == '0) &&
                      !((prev_x == '0) && (prev_y == '0));
    assign new_line = vga_posY != prev_y;

    // The first pixel of a new frame already uses the incoming mode.
    assign k_eff = fs_det ? scale_shift(scale_sel) : k_lat;
    assign c_eff = fs_det ? center_en : center_lat;

    assign px    = XW'(vga_posX);
    assign py    = XW'(vga_posY);
    assign win_w = XW'(CAM_X) << k_eff;
    assign win_h = XW'(CAM_Y) << k_eff;
    assign ox    = (c_eff && win_w <= XW'(H_ACTIVE)) ? (XW'(H_ACTIVE) - win_w) >> 1 : '0;
    assign oy    = (c_eff && win_h <= XW'(V_ACTIVE)) ? (XW'(V_ACTIVE) - win_h) >> 1 : '0;

    assign active = (state == ACTIVE) || fs_det;
    assign in_win = active &&
                    (px >= ox) && (px < ox + win_w) && (px < XW'(H_ACTIVE)) &&
                    (py >= oy) && (py < oy + win_h) && (py < XW'(V_ACTIVE));

    always_comb begin
        case (k_eff)
            2'd1:    rep_last = 2'd1;
            2'd2:    rep_last = 2'd3;
            default: rep_last = 2'd0;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave
        // one unassigned and infer a latch.
        hrep_n = hrep;
        col_n  = col;
        vrep_n = vrep;
        row_n  = row_base;

        if (px == ox) begin
            hrep_n = '0;
            col_n  = '0;
        end else if (hrep == rep_last) begin
            hrep_n = '0;
            col_n  = col + AW'(1);
        end else begin
            hrep_n = hrep + 2'd1;
        end

        // Row counters step once per new line; the top image row re-anchors them.
        if (fs_det || py == oy) begin
            vrep_n = '0;
            row_n  = '0;
        end else if (new_line) begin
            if (vrep == rep_last) begin
                vrep_n = '0;
                row_n  = row_base + ROW_STEP;
            end else begin
                vrep_n = vrep + 2'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: if (fs_det) state_next = ACTIVE;
            ACTIVE:     state_next = ACTIVE;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge.
        if (rst) begin
            state       <= WAIT_FRAME;
            k_lat       <= '0;
            center_lat  <= 1'b0;
            prev_x      <= '1;
            prev_y      <= '1;
            hrep        <= '0;
            col         <= '0;
            vrep        <= '0;
            row_base    <= '0;
            ram_addr    <= BLACK;
            win_q       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            prev_x      <= vga_posX;
            prev_y      <= vga_posY;
            hrep        <= hrep_n;
            col         <= col_n;
            vrep        <= vrep_n;
            row_base    <= row_n;
            ram_addr    <= in_win ? row_n + col_n : BLACK;
            win_q       <= in_win;
            frame_start <= fs_det;
            if (fs_det) begin
                k_lat      <= scale_shift(scale_sel);
                center_lat <= center_en;
            end
        end
    end

    pix_delay_line #(
        .DEPTH (RAM_LAT),
        .WIDTH (1)
    ) u_win_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (win_q),
        .dout (win_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pixel_out <= '0;
        else     pixel_out <= win_d ? ram_data : border_color;
    end

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Directed bench for vga_fb_scaler: one instance at RAM_LAT=1 and one at
// RAM_LAT=3, each fed by a RAM model that returns its address as data.
module tb_vga_fb_scaler;
    import cam_vga_pkg::*;

    localparam logic [DW-1:0] BORDER = 12'h5A3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    scale_sel = 2'd0;
    logic          center_en = 1'b0;
    logic [DW-1:0] border_color = BORDER;
    logic [9:0]    pos_x = 10'd700;
    logic [9:0]    pos_y = 10'd500;

    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b, pix_a, pix_b;
    logic          fs_a, fs_b;
    logic [AW-1:0] pipe_a;
    logic [AW-1:0] pipe_b [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    vga_fb_scaler #(.RAM_LAT(1)) dut_a (
        .clk (clk), .rst (rst), .scale_sel (scale_sel), .center_en (center_en),
        .border_color (border_color), .vga_posX (pos_x), .vga_posY (pos_y),
        .ram_addr (addr_a), .ram_data (data_a), .pixel_out (pix_a), .frame_start (fs_a)
    );

    vga_fb_scaler #(.RAM_LAT(3)) dut_b (
        .clk (clk), .rst (rst), .scale_sel (scale_sel), .center_en (center_en),
        .border_color (border_color), .vga_posX (pos_x), .vga_posY (pos_y),
        .ram_addr (addr_b), .ram_data (data_b), .pixel_out (pix_b), .frame_start (fs_b)
    );

    always @(posedge clk) begin
        pipe_a    <= addr_a;
        pipe_b[0] <= addr_b;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign data_a = pipe_a[DW-1:0];
    assign data_b = pipe_b[2][DW-1:0];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int x, input int y);
        pos_x = 10'(x);
        pos_y = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic skip_rows(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) drive(0, y);
    endtask

    // Scans a row from x0 to x1, checks the address for (x1,y), then the
    // pixel of each instance on the cycle its read latency dictates.
    task automatic scan_probe(input int y, input int x0, input int x1,
                              input int exp_addr, input string tag);
        int exp_pix;
        exp_pix = (exp_addr == BLACK_SLOT) ? int'(BORDER) : (exp_addr & 'hFFF);
        for (int x = x0; x < x1; x++) drive(x, y);
        drive(x1, y);
        check({tag, "_addr_a"}, int'(addr_a), exp_addr);
        check({tag, "_addr_b"}, int'(addr_b), exp_addr);
        drive(x1 + 1, y);
        drive(x1 + 2, y);
        check({tag, "_pix_a"}, int'(pix_a), exp_pix);
        drive(x1 + 3, y);
        drive(x1 + 4, y);
        check({tag, "_pix_b"}, int'(pix_b), exp_pix);
    endtask

    task automatic start_frame(input string tag);
        drive(0, 0);
        check({tag, "_fs_a"}, int'(fs_a), 1);
        check({tag, "_fs_b"}, int'(fs_b), 1);
        drive(1, 0);
        check({tag, "_fs_end_a"}, int'(fs_a), 0);
        check({tag, "_fs_end_b"}, int'(fs_b), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_addr_a", int'(addr_a), 19200);
        check("rst_addr_b", int'(addr_b), 19200);
        check("rst_pix_a", int'(pix_a), 0);
        check("rst_pix_b", int'(pix_b), 0);
        check("rst_fs_a", int'(fs_a), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Before any frame start only the border is shown.
        scan_probe(2, 0, 5, 19200, "wait");
        check("wait_fs", int'(fs_a), 0);

        // Frame A: 1x, top-left; the mode change mid-frame must not apply yet.
        start_frame("fa");
        scan_probe(0, 2, 160, 19200, "1x_160_0");
        skip_rows(1, 1);
        scan_probe(2, 0, 5, 325, "1x_5_2");
        scale_sel = 2'd2;
        skip_rows(3, 3);
        scan_probe(4, 0, 5, 645, "1x_held_5_4");
        skip_rows(5, 118);
        scan_probe(119, 0, 159, 19199, "1x_159_119");
        skip_rows(120, 479);

        // Frame B: 4x latched at the frame start.
        start_frame("fb");
        scale_sel = 2'd1;
        skip_rows(1, 3);
        scan_probe(4, 0, 4, 161, "4x_4_4");
        skip_rows(5, 478);
        scan_probe(479, 0, 639, 19199, "4x_639_479");

        // Frame C: 2x, top-left.
        start_frame("fc");
        scan_probe(0, 2, 320, 19200, "2x_320_0");
        skip_rows(1, 2);
        scan_probe(3, 0, 7, 163, "2x_7_3");
        skip_rows(4, 238);
        scan_probe(239, 0, 319, 19199, "2x_319_239");
        skip_rows(240, 479);

        // Frame D: 1x centred, origin (240,180).
        scale_sel = 2'd0;
        center_en = 1'b1;
        start_frame("fd");
        skip_rows(1, 179);
        scan_probe(180, 0, 239, 19200, "c_239_180");
        scan_probe(180, 0, 240, 0, "c_240_180");
        skip_rows(181, 298);
        scan_probe(299, 0, 399, 19199, "c_399_299");
        scan_probe(299, 0, 400, 19200, "c_400_299");
        skip_rows(300, 479);

        // Frame E: reserved code acts as 1x; then an asynchronous mid-frame reset.
        scale_sel = 2'd3;
        center_en = 1'b0;
        start_frame("fe");
        skip_rows(1, 1);
        scan_probe(2, 0, 5, 325, "rsv_5_2");
        skip_rows(3, 4);
        #5 rst = 1'b1;
        #1;
        check("mid_rst_addr_a", int'(addr_a), 19200);
        check("mid_rst_addr_b", int'(addr_b), 19200);
        check("mid_rst_pix_a", int'(pix_a), 0);
        check("mid_rst_pix_b", int'(pix_b), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        skip_rows(5, 9);
        scan_probe(10, 0, 5, 19200, "post_rst");
        skip_rows(11, 479);
        start_frame("ff");
        skip_rows(1, 1);
        scan_probe(2, 0, 5, 325, "ff_5_2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
